// File: rtl/echo_effect_pkg.sv
// Shared audio definitions: echo FSM states, default sample width and the
// saturation helper used by the effect stages.
package echo_effect_pkg;

  localparam int D_WIDTH_DEF    = 24;
  localparam int DELAY_LOG2_DEF = 12;

  typedef enum logic [3:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD_L,
    ST_MAC_L,
    ST_WR_L,
    ST_RD_R,
    ST_MAC_R,
    ST_WR_R,
    ST_DONE
  } echo_state_t;

  // Clamp a sign-extended value to the range of a w-bit two's complement word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/echo_effect_ram.sv
// Single-port synchronous RAM, one-cycle read latency, no reset so it maps to
// block RAM.
module echo_effect_ram #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 13
) (
  input  logic              mclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge mclk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_effect.sv
// Stereo feedback echo: y = sat(x + gain * y[n - 2^delay_log2]) per channel,
// processed once per ws falling edge through a shared single-port delay RAM.
module echo_effect
  import echo_effect_pkg::*;
#(
  parameter int d_width    = D_WIDTH_DEF,
  parameter int delay_log2 = DELAY_LOG2_DEF
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic               ws,
  input  logic               en,
  input  logic [7:0]         gain,
  input  logic [d_width-1:0] l_data_rx,
  input  logic [d_width-1:0] r_data_rx,
  output logic [d_width-1:0] l_data_tx,
  output logic [d_width-1:0] r_data_tx,
  output logic               done,
  output logic               busy
);

  localparam int AW = delay_log2 + 1;

  echo_state_t state, state_nx;

  logic                  ws_d;
  logic                  strobe;
  logic [delay_log2-1:0] ptr;
  logic [AW-1:0]         clr_cnt;

  logic signed [d_width-1:0] x_l, x_r, y_l, y_r, wb;

  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [d_width-1:0] ram_wdata, ram_rdata;

  logic signed [d_width-1:0] ram_q, x_sel, y_sat;
  logic signed [d_width+8:0] prod;
  logic signed [d_width:0]   p, s;
  logic signed [63:0]        s_ext, s_sat;
  logic                      unused_bits;

  assign strobe = ws_d & ~ws;
  assign busy   = (state != ST_IDLE);

  // ---------------- state register / next state ----------------
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= ST_CLEAR;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (clr_cnt == '1) state_nx = ST_IDLE;
      ST_IDLE:  if (strobe) state_nx = ST_RD_L;
      ST_RD_L:  state_nx = ST_MAC_L;
      ST_MAC_L: state_nx = ST_WR_L;
      ST_WR_L:  state_nx = ST_RD_R;
      ST_RD_R:  state_nx = ST_MAC_R;
      ST_MAC_R: state_nx = ST_WR_R;
      ST_WR_R:  state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  // ---------------- RAM port ----------------
  // The read address is held through RD_x so the data is on the RAM output
  // during MAC_x; writes and reads never share a cycle on the single port.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {1'b0, ptr};
    ram_wdata = '0;
    case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
      end
      ST_WR_L: begin
        ram_we    = 1'b1;
        ram_wdata = wb;
      end
      ST_RD_R, ST_MAC_R: ram_addr = {1'b1, ptr};
      ST_WR_R: begin
        ram_we    = 1'b1;
        ram_addr  = {1'b1, ptr};
        ram_wdata = wb;
      end
      default: ;
    endcase
  end

  echo_effect_ram #(
    .WIDTH  (d_width),
    .ADDR_W (AW)
  ) u_delay_ram (
    .mclk  (mclk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---------------- multiply-accumulate ----------------
  // Taking the upper bits of the product is an arithmetic shift, i.e. floor.
  always_comb begin
    ram_q = $signed(ram_rdata);
    x_sel = (state == ST_MAC_R) ? x_r : x_l;
    prod  = (d_width+9)'(ram_q) * (d_width+9)'($signed({1'b0, gain}));
    p     = prod[d_width+8:8];
    s     = {x_sel[d_width-1], x_sel} + p;
    s_ext = 64'(s);
    s_sat = sat_to_width(s_ext, d_width);
    y_sat = s_sat[d_width-1:0];
  end

  assign unused_bits = ^{prod[7:0], s_sat[63:d_width]};

  // ---------------- datapath registers ----------------
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ws_d      <= 1'b0;
      ptr       <= '0;
      clr_cnt   <= '0;
      x_l       <= '0;
      x_r       <= '0;
      y_l       <= '0;
      y_r       <= '0;
      wb        <= '0;
      l_data_tx <= '0;
      r_data_tx <= '0;
      done      <= 1'b0;
    end else begin
      ws_d <= ws;
      done <= 1'b0;
      case (state)
        ST_CLEAR: clr_cnt <= clr_cnt + AW'(1);
        ST_IDLE: if (strobe) begin
          x_l <= l_data_rx;
          x_r <= r_data_rx;
        end
        ST_MAC_L: begin
          y_l <= en ? y_sat : x_l;
          wb  <= en ? y_sat : '0;
        end
        ST_MAC_R: begin
          y_r <= en ? y_sat : x_r;
          wb  <= en ? y_sat : '0;
        end
        ST_DONE: begin
          l_data_tx <= y_l;
          r_data_tx <= y_r;
          done      <= 1'b1;
          ptr       <= ptr + delay_log2'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_effect.sv
// Bench for echo_effect (delay_log2 = 3): vector tables, hand sequences for
// clear / busy-drop / mid-frame reset, and random frames against a model.
module tb_echo_effect;

  localparam int DW = 24;
  localparam int DL = 3;
  localparam int NS = 8;

  logic          mclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ws = 1'b0;
  logic          en = 1'b0;
  logic [7:0]    gain = '0;
  logic [DW-1:0] l_rx = '0, r_rx = '0;
  logic [DW-1:0] l_tx, r_tx;
  logic          done, busy;

  echo_effect #(.d_width(DW), .delay_log2(DL)) dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .ws        (ws),
    .en        (en),
    .gain      (gain),
    .l_data_rx (l_rx),
    .r_data_rx (r_rx),
    .l_data_tx (l_tx),
    .r_data_tx (r_tx),
    .done      (done),
    .busy      (busy)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [DW-1:0] l, r;
    logic          e;
    logic [7:0]    g;
    logic [DW-1:0] el, er;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // reference: per-channel history of the last NS outputs fed back
  longint        mem_l[NS], mem_r[NS];
  int            mptr;
  logic [DW-1:0] prev_l, prev_r;

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sat24(input longint v);
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  function automatic longint echo_y(input longint m, input longint x, input logic [7:0] g);
    longint p;
    p = (m * longint'(g)) >>> 8;
    return sat24(x + p);
  endfunction

  task automatic model_reset;
    for (int i = 0; i < NS; i++) begin
      mem_l[i] = 0;
      mem_r[i] = 0;
    end
    mptr   = 0;
    prev_l = '0;
    prev_r = '0;
  endtask

  task automatic model_frame(input logic [DW-1:0] l, r, input logic e, input logic [7:0] g,
                             output logic [DW-1:0] el, er);
    longint xl, xr, yl, yr;
    xl = longint'($signed(l));
    xr = longint'($signed(r));
    yl = echo_y(mem_l[mptr], xl, g);
    yr = echo_y(mem_r[mptr], xr, g);
    if (e) begin
      el = yl[DW-1:0];
      er = yr[DW-1:0];
      mem_l[mptr] = yl;
      mem_r[mptr] = yr;
    end else begin
      el = l;
      er = r;
      mem_l[mptr] = 0;
      mem_r[mptr] = 0;
    end
    mptr = (mptr + 1) % NS;
  endtask

  // One 256-cycle frame; E0 is the edge that sees the ws fall.
  task automatic run_frame(input logic [DW-1:0] l, r, input logic e, input logic [7:0] g,
                           input logic [DW-1:0] el, er, input bit pair, input string nm);
    int dones;
    dones = 0;
    ws = 1'b1;
    repeat (127) tick;
    l_rx = l; r_rx = r; en = e; gain = g;
    tick;
    ws = 1'b0;
    tick;  // E0
    chk({nm, " busy@E0"}, busy, 1);
    for (int k = 1; k <= 7; k++) begin
      if (pair && k == 1) ws = 1'b1;
      if (pair && k == 3) ws = 1'b0;
      tick;
      if (done) dones++;
      if (k == 6) begin
        chk({nm, " done@E6"}, done, 0);
        chk({nm, " busy@E6"}, busy, 1);
        chk({nm, " l_tx@E6"}, l_tx, prev_l);
        chk({nm, " r_tx@E6"}, r_tx, prev_r);
      end
    end
    chk({nm, " done@E7"}, done, 1);
    chk({nm, " busy@E7"}, busy, 0);
    chk({nm, " l_tx"}, l_tx, el);
    chk({nm, " r_tx"}, r_tx, er);
    repeat (120) begin
      tick;
      if (done) dones++;
    end
    chk({nm, " done count"}, dones, 1);
    prev_l = el;
    prev_r = er;
  endtask

  task automatic frame_m(input logic [DW-1:0] l, r, input logic e, input logic [7:0] g,
                         input string nm);
    logic [DW-1:0] el, er;
    model_frame(l, r, e, g, el, er);
    run_frame(l, r, e, g, el, er, 1'b0, nm);
  endtask

  // Reset, then watch the clear with a strobe injected at cycle 5.
  task automatic apply_reset;
    ws = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) tick;
    chk("reset l_tx", l_tx, 0);
    chk("reset busy", busy, 1);
    reset_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 4) ws = 1'b1;
      if (c == 5) ws = 1'b0;
      tick;
      chk($sformatf("clear busy c%0d", c), busy, (c < 16) ? 1 : 0);
      chk($sformatf("clear done c%0d", c), done, 0);
      chk($sformatf("clear tx c%0d", c), {l_tx, r_tx}, 0);
    end
    repeat (4) begin
      tick;
      chk("post-clear idle", {done, busy}, 0);
    end
  endtask

  vec_t imp[18];
  vec_t sat[20];

  initial begin
    logic [DW-1:0] el, er, lr, rr;

    for (int i = 0; i < 18; i++) begin
      imp[i].l  = (i == 0) ? 24'h100000 : 24'h0;
      imp[i].r  = 24'h0;
      imp[i].e  = 1'b1;
      imp[i].g  = 8'h80;
      imp[i].el = (i == 0) ? 24'h100000 : (i == 8) ? 24'h080000 :
                  (i == 16) ? 24'h040000 : 24'h0;
      imp[i].er = 24'h0;
    end
    for (int i = 0; i < 20; i++) begin
      sat[i].l  = 24'h7FFFFF;
      sat[i].r  = 24'h800000;
      sat[i].e  = 1'b1;
      sat[i].g  = 8'hFF;
      sat[i].el = 24'h7FFFFF;
      sat[i].er = 24'h800000;
    end

    // reset, clear and ignored strobe
    apply_reset();

    // bypass
    model_frame(24'h123456, 24'hFEDCBA, 1'b0, 8'h80, el, er);
    run_frame(24'h123456, 24'hFEDCBA, 1'b0, 8'h80, 24'h123456, 24'hFEDCBA, 1'b0, "bypass");

    // impulse echo
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      model_frame(imp[i].l, imp[i].r, imp[i].e, imp[i].g, el, er);
      run_frame(imp[i].l, imp[i].r, imp[i].e, imp[i].g, imp[i].el, imp[i].er, 1'b0,
                $sformatf("impulse f%0d", i));
    end

    // saturation
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      model_frame(sat[i].l, sat[i].r, sat[i].e, sat[i].g, el, er);
      run_frame(sat[i].l, sat[i].r, sat[i].e, sat[i].g, sat[i].el, sat[i].er, 1'b0,
                $sformatf("sat f%0d", i));
    end

    // busy-drop then pointer wrap: impulse in frame 1 echoes in frame 9
    apply_reset();
    model_frame(24'h0, 24'h0, 1'b1, 8'h80, el, er);
    run_frame(24'h0, 24'h0, 1'b1, 8'h80, 24'h0, 24'h0, 1'b1, "pair f0");
    for (int i = 1; i <= 9; i++) begin
      lr = (i == 1) ? 24'h200000 : 24'h0;
      model_frame(lr, 24'h0, 1'b1, 8'h80, el, er);
      run_frame(lr, 24'h0, 1'b1, 8'h80,
                (i == 1) ? 24'h200000 : (i == 9) ? 24'h100000 : 24'h0, 24'h0, 1'b0,
                $sformatf("wrap f%0d", i));
    end

    // reset during MAC_R with a full delay line; no stale echo afterwards
    apply_reset();
    for (int i = 0; i < NS; i++) frame_m(24'h300000, 24'h300000, 1'b1, 8'h80, "prefill");
    ws = 1'b1;
    repeat (127) tick;
    l_rx = 24'h0; r_rx = 24'h0;
    tick;
    ws = 1'b0;
    repeat (5) tick;  // E0..E4, now in MAC_R
    chk("pre-abort l_tx", l_tx, 24'h300000);
    reset_n = 1'b0;
    #1;
    chk("abort l_tx", l_tx, 0);
    chk("abort r_tx", r_tx, 0);
    chk("abort done", done, 0);
    apply_reset();
    for (int i = 0; i <= 8; i++) begin
      lr = (i == 0) ? 24'h100000 : 24'h0;
      model_frame(lr, 24'h0, 1'b1, 8'h80, el, er);
      run_frame(lr, 24'h0, 1'b1, 8'h80,
                (i == 0) ? 24'h100000 : (i == 8) ? 24'h080000 : 24'h0, 24'h0, 1'b0,
                $sformatf("post-abort f%0d", i));
    end

    // random frames against the reference model
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      lr = 24'($urandom);
      rr = 24'($urandom);
      if ($urandom_range(0, 4) == 0) lr = 24'h7FFFFF;
      if ($urandom_range(0, 4) == 0) rr = 24'h800000;
      frame_m(lr, rr, ($urandom_range(0, 3) != 0), 8'($urandom), $sformatf("rand f%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
